packet_route_split_two: RTL and testbench

Clocked downstream stage that consumes the 33-bit packet stream produced by the two-input arbiter merge. It receives packets over a 4-phase bundled-data handshake, buffers them in a small FIFO, and routes each packet to one of two 4-phase output channels by a destination bit. It is the demux half of the router, re-splitting the merged stream toward two consumers.

---
 rtl/router_pkg.sv | 23 ++
 rtl/packet_route_split_two_if.sv | 20 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/packet_route_split_two.sv | 169 ++++++++++++++++
 tb/tb_packet_route_split_two.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the packet router demux stage.
// Contents:
//   PKT_WIDTH          - packet width produced by the upstream merge
//   ROUTE_BIT_DEFAULT  - packet bit that selects the output channel
//   in_state_e         - input-side handshake FSM states
//   out_state_e        - output-side handshake FSM states
package router_pkg;

    localparam int unsigned PKT_WIDTH         = 33;
    localparam int unsigned ROUTE_BIT_DEFAULT = 29;

    typedef enum logic {
        InIdle,
        InAck
    } in_state_e;

    typedef enum logic [1:0] {
        OutIdle,
        OutReq,
        OutRel
    } out_state_e;

endpackage

// File: rtl/packet_route_split_two_if.sv
// 4-phase bundled-data channel: one request, one acknowledge, one data bus.
// Ports (signals):
//   req  - request, driven by the producer
//   ack  - acknowledge, driven by the consumer
//   data - bundled data, stable while req is high
// Modports: master = producer side, slave = consumer side.
interface packet_route_split_two_if
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = PKT_WIDTH
);

    logic             req;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   push     - write din (ignored when full)
//   pop      - advance the read pointer (ignored when empty)
//   din      - write data
//   dout     - head entry (combinational read at the read pointer)
//   full     - count == DEPTH
//   empty    - count == 0
//   count    - current occupancy
module sync_fifo
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = PKT_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PtrW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage has no reset: stale entries are never visible because count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/packet_route_split_two.sv
// Demux stage of the router: accepts packets on a 4-phase input channel,
// buffers them in a FIFO and forwards each, in order, to out0 or out1
// depending on packet bit ROUTE_BIT.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_ch      - input channel (slave): req/data in, ack out
//   out0       - output channel 0 (master): req/data out, ack in
//   out1       - output channel 1 (master): req/data out, ack in
//   fifo_count - current FIFO occupancy
module packet_route_split_two
    import router_pkg::*;
#(
    parameter int unsigned WIDTH       = PKT_WIDTH,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ROUTE_BIT   = ROUTE_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    packet_route_split_two_if.slave   in_ch,
    packet_route_split_two_if.master  out0,
    packet_route_split_two_if.master  out1,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    // ---------------------------------------------------------------
    // Synchronizers: bit 0 = in req, bit 1 = out0 ack, bit 2 = out1 ack
    // ---------------------------------------------------------------
    logic [2:0] sync_raw;
    logic [2:0] sync_out;

    assign sync_raw = {out1.ack, out0.ack, in_ch.req};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain;

        always_ff @(posedge clk) begin
            if (rst) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], sync_raw[g]};
            end
        end

        assign sync_out[g] = chain[SYNC_STAGES-1];
    end

    logic req_s;
    logic ack0_s;
    logic ack1_s;

    assign req_s  = sync_out[0];
    assign ack0_s = sync_out[1];
    assign ack1_s = sync_out[2];

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_ch.data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    in_state_e        in_state;
    in_state_e        in_state_next;
    out_state_e       out_state;
    out_state_e       out_state_next;
    logic             out_sel;
    logic [WIDTH-1:0] data_reg;
    logic             sel_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state  <= InIdle;
            out_state <= OutIdle;
            out_sel   <= 1'b0;
            data_reg  <= '0;
        end else begin
            in_state  <= in_state_next;
            out_state <= out_state_next;
            // Data register only changes on a pop, so it stays stable for the
            // whole 4-phase cycle on the selected output.
            if (pop) begin
                data_reg <= fifo_dout;
                out_sel  <= fifo_dout[ROUTE_BIT];
            end
        end
    end

    // ---------------------------------------------------------------
    // Input FSM
    // ---------------------------------------------------------------
    always_comb begin
        in_state_next = in_state;
        push          = 1'b0;
        unique case (in_state)
            InIdle: begin
                // A full FIFO stalls here with ack low; upstream just waits.
                if (req_s && !fifo_full) begin
                    push          = 1'b1;
                    in_state_next = InAck;
                end
            end
            InAck: begin
                if (!req_s) begin
                    in_state_next = InIdle;
                end
            end
            default: in_state_next = InIdle;
        endcase
    end

    // ---------------------------------------------------------------
    // Output FSM
    // ---------------------------------------------------------------
    // Only the selected channel's ack matters; the other one is ignored.
    assign sel_ack = out_sel ? ack1_s : ack0_s;

    always_comb begin
        out_state_next = out_state;
        pop            = 1'b0;
        unique case (out_state)
            OutIdle: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    out_state_next = OutReq;
                end
            end
            OutReq: begin
                if (sel_ack) begin
                    out_state_next = OutRel;
                end
            end
            OutRel: begin
                if (!sel_ack) begin
                    out_state_next = OutIdle;
                end
            end
            default: out_state_next = OutIdle;
        endcase
    end

    // Outputs decode from registered state, so at most one req is ever high.
    assign in_ch.ack = (in_state == InAck);
    assign out0.req  = (out_state == OutReq) && !out_sel;
    assign out1.req  = (out_state == OutReq) && out_sel;
    assign out0.data = data_reg;
    assign out1.data = data_reg;

endmodule

// File: tb/tb_packet_route_split_two.sv
// Self-checking bench for packet_route_split_two: directed latency/boundary
// cases plus randomized traffic, checked against an in-order packet queue.
module tb_packet_route_split_two;
    import router_pkg::*;

    localparam int unsigned W     = 33;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RB    = 29;
    localparam int unsigned CW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    packet_route_split_two_if #(.WIDTH(W)) in_ch ();
    packet_route_split_two_if #(.WIDTH(W)) out0 ();
    packet_route_split_two_if #(.WIDTH(W)) out1 ();

    logic [CW-1:0] fifo_count;
    logic          in_req_drv;
    logic [W-1:0]  in_data_drv;
    logic [1:0]    ack_drv;

    assign in_ch.req  = in_req_drv;
    assign in_ch.data = in_data_drv;
    assign out0.ack   = ack_drv[0];
    assign out1.ack   = ack_drv[1];

    packet_route_split_two #(
        .WIDTH       (W),
        .DEPTH       (DEPTH),
        .ROUTE_BIT   (RB),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ch      (in_ch),
        .out0       (out0),
        .out1       (out1),
        .fifo_count (fifo_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: packets accepted upstream must leave in the same
    // order, each on the channel named by its route bit.
    // ---------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           count_m;
    logic         prev_ack;
    logic [1:0]   prev_req;
    logic [W-1:0] cur [2];
    int           rx_cnt [2];
    logic [W-1:0] last_rx [2];
    logic [1:0]   mon_r;
    logic [W-1:0] mon_d [2];
    logic [W-1:0] mon_e;

    initial begin
        count_m  = 0;
        prev_ack = 1'b0;
        prev_req = 2'b00;
        rx_cnt   = '{0, 0};
        last_rx  = '{'0, '0};
        cur      = '{'0, '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                count_m  = 0;
                prev_ack = 1'b0;
                prev_req = 2'b00;
            end else begin
                mon_r    = {out1.req, out0.req};
                mon_d[0] = out0.data;
                mon_d[1] = out1.data;
                check("req_mutex", {63'b0, &mon_r}, 64'd0);
                if (in_ch.ack && !prev_ack) begin
                    exp_q.push_back(in_data_drv);
                    count_m++;
                end
                for (int c = 0; c < 2; c++) begin
                    if (mon_r[c] && !prev_req[c]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_req: ch%0d data %0h, expected no request",
                                     c, mon_d[c]);
                        end else begin
                            mon_e  = exp_q.pop_front();
                            cur[c] = mon_e;
                            count_m--;
                            check("route_channel", 64'(c), {63'b0, mon_e[RB]});
                            check("pop_data", {31'b0, mon_d[c]}, {31'b0, mon_e});
                            rx_cnt[c]++;
                            last_rx[c] = mon_d[c];
                        end
                    end else if (mon_r[c]) begin
                        check("data_stable", {31'b0, mon_d[c]}, {31'b0, cur[c]});
                    end
                end
                check("fifo_count", {61'b0, fifo_count}, 64'(count_m));
                prev_ack = in_ch.ack;
                prev_req = mon_r;
            end
        end
    end

    // ---------------------------------------------------------------
    // Consumers: raise ack ack_dly cycles after seeing req, drop after req falls
    // ---------------------------------------------------------------
    logic [1:0] ack_en;
    logic [1:0] ack_rand;
    int         ack_dly [2];
    int         ack_cnt [2];

    initial begin
        ack_drv = 2'b00;
        ack_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                logic rq;
                rq = (c == 0) ? out0.req : out1.req;
                if (rst) begin
                    ack_drv[c] = 1'b0;
                    ack_cnt[c] = 0;
                end else if (!ack_drv[c]) begin
                    if (rq && ack_en[c]) begin
                        if (ack_cnt[c] >= ack_dly[c]) begin
                            ack_drv[c] = 1'b1;
                            ack_cnt[c] = 0;
                        end else begin
                            ack_cnt[c]++;
                        end
                    end
                end else if (!rq) begin
                    ack_drv[c] = 1'b0;
                    if (ack_rand[c]) ack_dly[c] = int'($urandom_range(0, 7));
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Producer helpers
    // ---------------------------------------------------------------
    task automatic wait_in_ack(input logic v, input string name);
        int n = 0;
        while (in_ch.ack !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'b0, in_ch.ack}, {63'b0, v});
    endtask

    task automatic send(input logic [W-1:0] p);
        in_data_drv = p;
        in_req_drv  = 1'b1;
        wait_in_ack(1'b1, "send_ack_rise");
        in_req_drv  = 1'b0;
        wait_in_ack(1'b0, "send_ack_fall");
    endtask

    task automatic wait_idle();
        int  n    = 0;
        bit  done = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            done = (exp_q.size() == 0) && (count_m == 0) && !out0.req && !out1.req &&
                   (ack_drv == 2'b00) && !in_ch.ack;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL idle_timeout: queue=%0d count=%0d, expected drained",
                     exp_q.size(), count_m);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int base0;
        int base1;
        int n0;
        int n1;
        logic [W-1:0] p;

        rst         = 1'b1;
        in_req_drv  = 1'b0;
        in_data_drv = '0;
        ack_en      = 2'b11;
        ack_rand    = 2'b00;
        ack_dly     = '{0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ack", {63'b0, in_ch.ack}, 64'd0);
        check("rst_out0_req", {63'b0, out0.req}, 64'd0);
        check("rst_out1_req", {63'b0, out1.req}, 64'd0);
        check("rst_out0_data", {31'b0, out0.data}, 64'd0);
        check("rst_out1_data", {31'b0, out1.data}, 64'd0);
        check("rst_fifo_count", {61'b0, fifo_count}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Test 1: latency of a single route-0 packet
        in_data_drv = 33'h0_0000_0015;
        in_req_drv  = 1'b1;
        @(negedge clk);                        // after edge 0
        @(negedge clk);                        // after edge 1
        check("t1_in_ack_edge1", {63'b0, in_ch.ack}, 64'd0);
        @(negedge clk);                        // after edge 2
        check("t1_in_ack_edge2", {63'b0, in_ch.ack}, 64'd1);
        check("t1_out0_req_edge2", {63'b0, out0.req}, 64'd0);
        @(negedge clk);                        // after edge 3
        check("t1_out0_req_edge3", {63'b0, out0.req}, 64'd1);
        check("t1_out0_data", {31'b0, out0.data}, 64'h15);
        check("t1_out1_req", {63'b0, out1.req}, 64'd0);
        in_req_drv = 1'b0;
        wait_in_ack(1'b0, "t1_ack_fall");
        wait_idle();
        check("t1_rx0", 64'(rx_cnt[0]), 64'd1);

        // Test 2: route-1 packet
        send(33'h0_2000_0007);
        wait_idle();
        check("t2_rx1", 64'(rx_cnt[1]), 64'd1);
        check("t2_last1", {31'b0, last_rx[1]}, 64'h2000_0007);
        check("t2_fifo_count", {61'b0, fifo_count}, 64'd0);

        // Test 3: stalled consumer fills the FIFO; sixth packet must stall
        base0     = rx_cnt[0];
        ack_en[0] = 1'b0;
        for (int i = 1; i <= 5; i++) send(W'(33'h100 + i));
        repeat (4) @(negedge clk);
        check("t3_count_full", {61'b0, fifo_count}, 64'd4);
        check("t3_out0_req", {63'b0, out0.req}, 64'd1);
        check("t3_out0_data", {31'b0, out0.data}, 64'h101);
        in_data_drv = 33'h106;
        in_req_drv  = 1'b1;
        repeat (10) @(negedge clk);
        check("t3_sixth_stalled", {63'b0, in_ch.ack}, 64'd0);
        ack_dly[0] = 2;
        ack_en[0]  = 1'b1;
        wait_in_ack(1'b1, "t3_sixth_ack");
        in_req_drv = 1'b0;
        wait_in_ack(1'b0, "t3_sixth_fall");
        wait_idle();
        check("t3_rx0_delta", 64'(rx_cnt[0] - base0), 64'd6);
        check("t3_last0", {31'b0, last_rx[0]}, 64'h106);

        // Test 4: alternating routes, both consumers ack after 3 cycles
        base0   = rx_cnt[0];
        base1   = rx_cnt[1];
        ack_dly = '{3, 3};
        for (int i = 0; i < 6; i++) begin
            p = W'(33'h40 + i);
            p[RB] = i[0];
            send(p);
        end
        wait_idle();
        check("t4_rx0_delta", 64'(rx_cnt[0] - base0), 64'd3);
        check("t4_rx1_delta", 64'(rx_cnt[1] - base1), 64'd3);

        // Test 5: reset while out0 is requesting with two packets queued
        ack_en[0] = 1'b0;
        for (int i = 1; i <= 3; i++) send(W'(33'h200 + i));
        repeat (3) @(negedge clk);
        check("t5_count_pre", {61'b0, fifo_count}, 64'd2);
        check("t5_out0_req_pre", {63'b0, out0.req}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);                        // after the reset edge
        check("t5_out0_req_rst", {63'b0, out0.req}, 64'd0);
        check("t5_in_ack_rst", {63'b0, in_ch.ack}, 64'd0);
        check("t5_count_rst", {61'b0, fifo_count}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ack_en[0] = 1'b1;
        @(negedge clk);
        base1 = rx_cnt[1];
        send(33'h0_2000_00AA);
        wait_idle();
        check("t5_rx1_delta", 64'(rx_cnt[1] - base1), 64'd1);
        check("t5_last1", {31'b0, last_rx[1]}, 64'h2000_00AA);

        // Test 6: random traffic from two merged sources, random ack delays
        base0    = rx_cnt[0];
        base1    = rx_cnt[1];
        n0       = 0;
        n1       = 0;
        ack_rand = 2'b11;
        ack_dly  = '{int'($urandom_range(0, 7)), int'($urandom_range(0, 7))};
        for (int i = 0; i < 15; i++) begin
            p = {1'($urandom_range(0, 1)), 32'($urandom())};
            if (p[RB]) n1++;
            else       n0++;
            send(p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check("t6_rx0_delta", 64'(rx_cnt[0] - base0), 64'(n0));
        check("t6_rx1_delta", 64'(rx_cnt[1] - base1), 64'(n1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
